sync_updown_counter: RTL and testbench
======================================

// Module: sync_updown_counter
// PURPOSE
//   Parametrised synchronous modulo-N binary counter. Generalised successor to the
//   team's fixed 4-bit 161-style counter: width and modulus are parameters, it counts
//   up or down, and it has a cascade enable input and a registered wrap pulse.
//   Used as a divider and sequencer building block. Instances chain through co -> cin.
// PARAMETERS
//   WIDTH    4   counter width in bits (1..16)
//   MODULUS  16  count range is 0..MODULUS-1; legal range is 2..2**WIDTH
//                (elaboration error if out of range)
// PORTS
//   clk    in   1      rising-edge clock
//   mr     in   1      master reset, asynchronous, active-low
//   load   in   1      synchronous parallel load, active-high
//   en     in   1      count enable (local), active-high
//   cin    in   1      cascade enable; tie 1 when not cascaded
//   up     in   1      direction: 1 = up, 0 = down
//   d      in   WIDTH  parallel load value
//   q      out  WIDTH  current count
//   co     out  1      terminal-count carry/borrow, combinational
//   wrap   out  1      registered one-cycle pulse after each wrap-around
// BEHAVIOUR
//   Reset:
//   - mr=0 forces q=0 and wrap=0 immediately, independent of clk.
//   - co follows the terminal-count rule: after reset, co=1 only if up=0 and cin=1.
//   - On mr release, the first counting edge is the first rising clk edge with mr=1.
//   Priority at each rising clk edge, with mr=1:
//   - load > count > hold.
//   - load=1: q <= d if d < MODULUS, else q <= MODULUS-1. This happens regardless of
//     en, cin and up. wrap <= 0.
//   - load=0, en=1, cin=1, up=1: q <= (q==MODULUS-1) ? 0 : q+1.
//   - load=0, en=1, cin=1, up=0: q <= (q==0) ? MODULUS-1 : q-1.
//   - Otherwise q holds and wrap <= 0.
//   Carry and wrap:
//   - co = cin & (up ? q==MODULUS-1 : q==0). co does not depend on en or load.
//     This matches 161 RCO, so a cascaded stage advances when both en and cin are high.
//   - wrap <= 1 for exactly one cycle after an edge that took the wrap branch
//     (MODULUS-1 -> 0 going up, or 0 -> MODULUS-1 going down). Otherwise wrap <= 0.
//   Latency and widths:
//   - q changes one clk edge after load or count conditions are sampled.
//   - co reacts combinationally to q, cin and up.
//   - All arithmetic is WIDTH-bit. The counter never holds a value >= MODULUS.
//   Boundary cases:
//   - Direction change mid-count takes effect on the next edge. No extra state.
//   - load and count in the same cycle: load wins.
//   - load of MODULUS-1 with up=1 gives co=1 on the following cycle.
//   - mr asserted mid-count: q=0 at once. A pending wrap pulse is cleared.
//   - MODULUS = 2**WIDTH: the wrap compare must still work (natural rollover).
// TESTING
//   Use WIDTH=4, MODULUS=10 unless noted.
//   1. Reset: mr=0 with load=1, d=7 and clocks running -> q=0, wrap=0.
//      Release mr, en=cin=up=1, 3 edges -> q=3.
//   2. Up wrap: load d=8, then en=cin=up=1. Edge1 -> q=9, co=1. Edge2 -> q=0, wrap=1
//      for one cycle, co=0.
//   3. Down wrap: load d=1, then up=0, en=cin=1. Edge1 -> q=0, co=1. Edge2 -> q=9,
//      wrap=1.
//   4. Priority and clamp: en=cin=1, load=1, d=4'd13 -> q=9.
//      load=1 with en=0 and d=3 -> q=3.
//      en=1, cin=0 -> q holds, co=0.
//   5. Cascade: two instances, low.co -> high.cin, all en=1, up=1. After 100 edges
//      from 0 -> {high.q, low.q} = {0, 0}. After 99 edges -> {9, 9}, high.co=1.
//   6. Async reset mid-count: assert mr between edges at q=6 -> q=0 before the next
//      edge. WIDTH=4, MODULUS=16 run -> 15 -> 0 with wrap=1.

Source files
------------

// File: rtl/sync_updown_counter.sv
// sync_updown_counter
//   Synchronous modulo-MODULUS up/down binary counter with parallel load,
//   cascade enable and a registered wrap pulse. Stages chain co -> cin.
// Ports
//   clk   : rising-edge clock
//   mr    : master reset, asynchronous, active-low
//   load  : synchronous parallel load (highest priority), clamps to MODULUS-1
//   en    : local count enable
//   cin   : cascade enable, tie high when not cascaded
//   up    : direction, 1 = up, 0 = down
//   d     : parallel load value
//   q     : current count (registered)
//   co    : terminal-count carry/borrow (combinational)
//   wrap  : one-cycle pulse after each wrap-around (registered)
module sync_updown_counter #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 16
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             load,
  input  logic             en,
  input  logic             cin,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             co,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 32'd1);

  // Reject illegal parameter combinations at elaboration.
  generate
    if (WIDTH < 32'd1 || WIDTH > 32'd16 || MODULUS < 32'd2 ||
        MODULUS > (32'd1 << WIDTH)) begin : g_bad_param
      $error("sync_updown_counter: illegal WIDTH/MODULUS");
    end
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_count;
  logic             w_d_ok;

  assign w_at_max  = (r_q == MAX_Q);
  assign w_at_zero = (r_q == '0);
  assign w_count   = en & cin;
  // Widen d so the compare also works when MODULUS == 2**WIDTH.
  assign w_d_ok    = (32'(d) < MODULUS);

  // Next-state selection: load > count > hold.
  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    if (load) begin
      w_q_nxt = w_d_ok ? d : MAX_Q;
    end else if (w_count) begin
      if (up) begin
        w_q_nxt    = w_at_max ? '0 : r_q + WIDTH'(1);
        w_wrap_nxt = w_at_max;
      end else begin
        w_q_nxt    = w_at_zero ? MAX_Q : r_q - WIDTH'(1);
        w_wrap_nxt = w_at_zero;
      end
    end
  end

  // Count and wrap registers.
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      r_q    <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  // Terminal count is independent of en and load, matching 161 RCO.
  assign co   = cin & (up ? w_at_max : w_at_zero);
  assign q    = r_q;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_sync_updown_counter.sv
module tb_sync_updown_counter;

  localparam int M = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance: WIDTH=4, MODULUS=10
  logic       mr, load, en, cin, up;
  logic [3:0] d;
  logic [3:0] q;
  logic       co, wrap;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .mr(mr), .load(load), .en(en), .cin(cin), .up(up),
    .d(d), .q(q), .co(co), .wrap(wrap)
  );

  // Cascade pair: low.co -> high.cin
  logic       cmr;
  logic [3:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_wrap, hi_wrap;

  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
    .clk(clk), .mr(cmr), .load(1'b0), .en(1'b1), .cin(1'b1), .up(1'b1),
    .d(4'd0), .q(lo_q), .co(lo_co), .wrap(lo_wrap)
  );
  sync_updown_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
    .clk(clk), .mr(cmr), .load(1'b0), .en(1'b1), .cin(lo_co), .up(1'b1),
    .d(4'd0), .q(hi_q), .co(hi_co), .wrap(hi_wrap)
  );

  // Full-range instance: WIDTH=4, MODULUS=16
  logic       fmr, fload, fen, fup;
  logic [3:0] fd, fq;
  logic       fco, fwrap;

  sync_updown_counter #(.WIDTH(4), .MODULUS(16)) u_full (
    .clk(clk), .mr(fmr), .load(fload), .en(fen), .cin(1'b1), .up(fup),
    .d(fd), .q(fq), .co(fco), .wrap(fwrap)
  );

  int total = 0;
  int bad   = 0;

  // Reference model of the main instance (plain modular arithmetic).
  int mq = 0;
  int mw = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model_co();
    if (!cin) return 0;
    return up ? int'(mq == M - 1) : int'(mq == 0);
  endfunction

  // Advance the model from the currently driven inputs, take one edge, settle.
  task automatic tick();
    if (!mr) begin
      mq = 0; mw = 0;
    end else if (load) begin
      mq = (int'(d) < M) ? int'(d) : M - 1;
      mw = 0;
    end else if (en && cin) begin
      if (up) begin
        mw = (mq == M - 1) ? 1 : 0;
        mq = (mq + 1) % M;
      end else begin
        mw = (mq == 0) ? 1 : 0;
        mq = (mq + M - 1) % M;
      end
    end else begin
      mw = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_main(input string tag);
    chk({tag, ".q"},    32'(q),    32'(mq));
    chk({tag, ".wrap"}, 32'(wrap), 32'(mw));
    chk({tag, ".co"},   32'(co),   32'(model_co()));
  endtask

  initial begin
    mr = 1'b0; load = 1'b1; en = 1'b1; cin = 1'b1; up = 1'b1; d = 4'd7;
    cmr = 1'b0;
    fmr = 1'b0; fload = 1'b0; fen = 1'b0; fup = 1'b1; fd = 4'd0;

    // 1. Reset dominates load while clocks run
    tick(); tick();
    chk("rst.q", 32'(q), 32'd0);
    chk("rst.wrap", 32'(wrap), 32'd0);
    chk("rst.co_up", 32'(co), 32'd0);
    up = 1'b0; #1;
    chk("rst.co_down", 32'(co), 32'd1);
    mr = 1'b1; load = 1'b0; up = 1'b1;
    tick(); tick(); tick();
    chk("rst.count3", 32'(q), 32'd3);
    chk_main("rst.model");

    // 2. Up wrap
    load = 1'b1; d = 4'd8; tick(); chk_main("upw.load");
    load = 1'b0;
    tick(); chk("upw.q9", 32'(q), 32'd9); chk("upw.co1", 32'(co), 32'd1);
    tick(); chk("upw.q0", 32'(q), 32'd0); chk("upw.wrap", 32'(wrap), 32'd1);
    chk("upw.co0", 32'(co), 32'd0);
    tick(); chk("upw.wrap_gone", 32'(wrap), 32'd0); chk_main("upw.model");

    // 3. Down wrap
    load = 1'b1; d = 4'd1; tick();
    load = 1'b0; up = 1'b0;
    tick(); chk("dnw.q0", 32'(q), 32'd0); chk("dnw.co1", 32'(co), 32'd1);
    tick(); chk("dnw.q9", 32'(q), 32'd9); chk("dnw.wrap", 32'(wrap), 32'd1);
    chk_main("dnw.model");

    // 4. Priority and clamp
    up = 1'b1; en = 1'b1; cin = 1'b1; load = 1'b1; d = 4'd13;
    tick(); chk("clamp.q", 32'(q), 32'd9); chk("clamp.co", 32'(co), 32'd1);
    en = 1'b0; d = 4'd3;
    tick(); chk("load_noen.q", 32'(q), 32'd3);
    load = 1'b0; en = 1'b1; cin = 1'b0;
    tick(); chk("cin0.hold", 32'(q), 32'd3); chk("cin0.co", 32'(co), 32'd0);
    chk_main("prio.model");

    // Randomized run against the model
    for (int i = 0; i < 400; i++) begin
      load = ($urandom_range(0, 9) == 0);
      en   = ($urandom_range(0, 4) != 0);
      cin  = ($urandom_range(0, 4) != 0);
      up   = 1'($urandom);
      d    = 4'($urandom);
      #1;
      chk("rand.co_pre", 32'(co), 32'(model_co()));
      tick();
      chk_main("rand");
    end

    // 6a. Async reset between edges at q=6
    load = 1'b1; d = 4'd5; en = 1'b1; cin = 1'b1; up = 1'b1; tick();
    load = 1'b0; tick(); chk("async.q6", 32'(q), 32'd6);
    #2; mr = 1'b0; #1;
    chk("async.q0", 32'(q), 32'd0);
    mq = 0; mw = 0;
    #3; mr = 1'b1;   // release mid-cycle, away from any edge
    tick(); chk_main("async.after");

    // 6b. Async reset clears a pending wrap pulse
    load = 1'b1; d = 4'd9; tick();
    load = 1'b0; tick(); chk("async.wrap_set", 32'(wrap), 32'd1);
    #2; mr = 1'b0; #1;
    chk("async.wrap_clr", 32'(wrap), 32'd0);
    chk("async.q_clr", 32'(q), 32'd0);
    mq = 0; mw = 0;
    en = 1'b0; #3; mr = 1'b1;

    // 5. Cascade: 99 edges -> {9,9}, 100 edges -> {0,0}
    #2; cmr = 1'b1;
    for (int i = 0; i < 99; i++) tick();
    chk("casc99.lo", 32'(lo_q), 32'd9);
    chk("casc99.hi", 32'(hi_q), 32'd9);
    chk("casc99.hico", 32'(hi_co), 32'd1);
    tick();
    chk("casc100.lo", 32'(lo_q), 32'd0);
    chk("casc100.hi", 32'(hi_q), 32'd0);
    chk("casc100.hiwrap", 32'(hi_wrap), 32'd1);
    chk("casc100.hico", 32'(hi_co), 32'd0);

    // 6c. MODULUS = 2**WIDTH natural rollover
    fmr = 1'b1; fload = 1'b1; fd = 4'd14; tick();
    chk("full.load", 32'(fq), 32'd14);
    fload = 1'b0; fen = 1'b1; fup = 1'b1;
    tick(); chk("full.q15", 32'(fq), 32'd15); chk("full.co", 32'(fco), 32'd1);
    tick(); chk("full.q0", 32'(fq), 32'd0); chk("full.wrap", 32'(fwrap), 32'd1);
    fup = 1'b0;
    tick(); chk("full.dn15", 32'(fq), 32'd15); chk("full.dnwrap", 32'(fwrap), 32'd1);
    tick(); chk("full.dn14", 32'(fq), 32'd14); chk("full.nowrap", 32'(fwrap), 32'd0);

    chk_main("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
